pln_seq: RTL and testbench

PLN_SEQ -- requirements
Module: pln_seq

---
 rtl/pln_seq.sv | 168 ++++++++++++++++
 tb/tb_pln_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pln_seq.sv
// rtl/pln_seq.sv - multi-cycle instruction pipeline sequencer with bus timeout
module pln_seq #(
    parameter int PC_W        = 16,
    parameter int PC_RESET    = 0,
    parameter int SKIP_W      = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              resume,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic              dec_mem_access,
    input  logic              dec_mem_write,
    input  logic              halt_req,
    input  logic              ex_branch_taken,
    input  logic              ex_branch_abs,
    input  logic [PC_W-1:0]   ex_target,
    input  logic [SKIP_W-1:0] ex_skip,
    input  logic              wb_en,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              rf_we_strobe,
    output logic [2:0]        stage,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic              bus_err,
    output logic [15:0]       instr_count
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        MEM_WAIT  = 3'd4,
        WRITEBACK = 3'd5,
        HALT      = 3'd6,
        ERROR     = 3'd7
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;
    logic              waiting;
    logic              mem_access_r;
    logic              mem_write_r;
    logic              br_taken_r;
    logic              br_abs_r;
    logic [PC_W-1:0]   target_r;
    logic [SKIP_W-1:0] skip_r;
    logic [PC_W-1:0]   pc_next;
    logic              wb_retire;
    logic              halt_retire;

    // The last permitted no-ack cycle; an ack arriving in it still wins.
    assign tmo_hit = (tmo_cnt == TW'(MEM_TIMEOUT - 1));

    // Cycles in which the sequencer is waiting on a bus acknowledge that has not come.
    assign waiting = ((state == FETCH) && !imem_ack) || ((state == MEM_WAIT) && !dmem_ack);

    assign wb_retire   = (state == WRITEBACK) && !stall;
    assign halt_retire = (state == HALT) && resume;

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_ack)     state_next = DECODE;
                else if (tmo_hit) state_next = ERROR;
            end
            DECODE: begin
                if (!stall) state_next = halt_req ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (!stall) state_next = mem_access_r ? MEMORY : WRITEBACK;
            end
            MEMORY:   state_next = MEM_WAIT;
            MEM_WAIT: begin
                if (dmem_ack)     state_next = WRITEBACK;
                else if (tmo_hit) state_next = ERROR;
            end
            WRITEBACK: begin
                if (!stall) state_next = FETCH;
            end
            HALT: begin
                if (resume) state_next = FETCH;
            end
            ERROR:    state_next = ERROR;
            default:  state_next = ERROR;
        endcase
    end

    // Branch resolution for the retiring instruction, modulo 2^PC_W.
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (br_taken_r) begin
            if (br_abs_r) pc_next = target_r;
            else          pc_next = pc + PC_W'(1) + PC_W'(skip_r);
        end
    end

    // State register and timeout counter; the counter restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            tmo_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) tmo_cnt <= '0;
            else if (waiting)        tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Capture decode and execute fields only when those stages advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_access_r <= 1'b0;
            mem_write_r  <= 1'b0;
            br_taken_r   <= 1'b0;
            br_abs_r     <= 1'b0;
            target_r     <= '0;
            skip_r       <= '0;
        end else begin
            if ((state == DECODE) && !stall) begin
                mem_access_r <= dec_mem_access;
                mem_write_r  <= dec_mem_write;
            end
            if ((state == EXECUTE) && !stall) begin
                br_taken_r <= ex_branch_taken;
                br_abs_r   <= ex_branch_abs;
                target_r   <= ex_target;
                skip_r     <= ex_skip;
            end
        end
    end

    // Architectural state: pc, retired count and the halted / sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= PC_W'(PC_RESET);
            instr_count <= '0;
            halted      <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            if (wb_retire)        pc <= pc_next;
            else if (halt_retire) pc <= pc + PC_W'(1);
            if ((wb_retire || halt_retire) && (instr_count != 16'hFFFF))
                instr_count <= instr_count + 16'd1;
            halted  <= (state_next == HALT);
            bus_err <= bus_err || (state_next == ERROR);
        end
    end

    // Requests follow the state; reset gates them so they drop while reset is held.
    assign stage        = state;
    assign imem_req     = rst && (state == FETCH);
    assign dmem_req     = rst && ((state == MEMORY) || (state == MEM_WAIT));
    assign dmem_we      = dmem_req && mem_write_r;
    assign rf_we_strobe = rst && wb_retire && wb_en;

endmodule

// File: tb/tb_pln_seq.sv
// tb/tb_pln_seq.sv - self-checking bench for pln_seq
module tb_pln_seq;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        resume;
    logic        imem_req;
    logic        imem_ack;
    logic        dec_mem_access;
    logic        dec_mem_write;
    logic        halt_req;
    logic        ex_branch_taken;
    logic        ex_branch_abs;
    logic [15:0] ex_target;
    logic [1:0]  ex_skip;
    logic        wb_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we_strobe;
    logic [2:0]  stage;
    logic [15:0] pc;
    logic        halted;
    logic        bus_err;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    pln_seq #(.PC_W(16), .PC_RESET(0), .SKIP_W(2), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .stall(stall), .resume(resume),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dec_mem_access(dec_mem_access), .dec_mem_write(dec_mem_write),
        .halt_req(halt_req), .ex_branch_taken(ex_branch_taken),
        .ex_branch_abs(ex_branch_abs), .ex_target(ex_target), .ex_skip(ex_skip),
        .wb_en(wb_en), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we_strobe(rf_we_strobe), .stage(stage), .pc(pc), .halted(halted),
        .bus_err(bus_err), .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem;
        logic        we;
        logic        taken;
        logic        abs_b;
        logic [15:0] target;
        logic [1:0]  skip;
        logic        wb;
        int          delay;
        logic [15:0] exp_pc;
        logic [15:0] exp_cnt;
        int          exp_cyc;
        int          exp_dreq;
        int          exp_strobe;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic mem, input logic we, input logic taken,
                                input logic abs_b, input logic [15:0] target,
                                input logic [1:0] skip, input logic wb, input int delay,
                                input logic [15:0] exp_pc, input logic [15:0] exp_cnt);
        vec_t v;
        v.mem = mem; v.we = we; v.taken = taken; v.abs_b = abs_b;
        v.target = target; v.skip = skip; v.wb = wb; v.delay = delay;
        v.exp_pc = exp_pc; v.exp_cnt = exp_cnt;
        v.exp_cyc    = mem ? 6 + delay : 4;
        v.exp_dreq   = mem ? delay + 2 : 0;
        v.exp_strobe = wb ? 1 : 0;
        return v;
    endfunction

    task automatic drive_instr(input vec_t v);
        dec_mem_access  = v.mem;
        dec_mem_write   = v.we;
        halt_req        = 1'b0;
        ex_branch_taken = v.taken;
        ex_branch_abs   = v.abs_b;
        ex_target       = v.target;
        ex_skip         = v.skip;
        wb_en           = v.wb;
        imem_ack        = 1'b1;
        dmem_ack        = 1'b0;
    endtask

    // Called just after a falling edge with the DUT in FETCH; returns in the next FETCH.
    task automatic run_instr(input string tag, input vec_t v);
        int cyc, waits, strobes, dreq, we_bad;
        cyc = 0; waits = 0; strobes = 0; dreq = 0; we_bad = 0;
        drive_instr(v);
        do begin
            if (dmem_req) begin
                dreq++;
                if (dmem_we !== v.we) we_bad++;
            end
            if (stage == 3'd4) begin
                dmem_ack = (waits == v.delay);
                waits++;
            end else begin
                dmem_ack = 1'b0;
            end
            if (rf_we_strobe) strobes++;
            @(negedge clk);
            cyc++;
        end while (stage != 3'd0 && cyc < 60);
        dmem_ack = 1'b0;
        check({tag, " cycles"}, cyc, v.exp_cyc);
        check({tag, " pc"}, pc, v.exp_pc);
        check({tag, " instr_count"}, instr_count, v.exp_cnt);
        check({tag, " rf_we pulses"}, strobes, v.exp_strobe);
        check({tag, " dmem_req cycles"}, dreq, v.exp_dreq);
        check({tag, " dmem_we"}, we_bad, 0);
    endtask

    task automatic wait_stage(input string tag, input logic [2:0] s, input int max);
        int n;
        n = 0;
        while (stage != s && n < max) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reached stage"}, stage, s);
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        rst = 1'b0; stall = 1'b0; resume = 1'b0; imem_ack = 1'b0;
        dec_mem_access = 1'b0; dec_mem_write = 1'b0; halt_req = 1'b0;
        ex_branch_taken = 1'b0; ex_branch_abs = 1'b0; ex_target = '0; ex_skip = '0;
        wb_en = 1'b0; dmem_ack = 1'b0;

        tbl[0]  = mk(0, 0, 0, 0, 16'h0000, 2'd0, 1,  0, 16'h0001, 16'd1);
        tbl[1]  = mk(0, 0, 0, 0, 16'h0000, 2'd0, 1,  0, 16'h0002, 16'd2);
        tbl[2]  = mk(0, 0, 0, 0, 16'h0000, 2'd0, 0,  0, 16'h0003, 16'd3);
        tbl[3]  = mk(1, 1, 0, 0, 16'h0000, 2'd0, 0,  3, 16'h0004, 16'd4);
        tbl[4]  = mk(1, 0, 0, 0, 16'h0000, 2'd0, 1,  0, 16'h0005, 16'd5);
        tbl[5]  = mk(0, 0, 1, 1, 16'h0010, 2'd0, 0,  0, 16'h0010, 16'd6);
        tbl[6]  = mk(0, 0, 1, 0, 16'h0000, 2'd2, 1,  0, 16'h0013, 16'd7);
        tbl[7]  = mk(0, 0, 1, 1, 16'hFFFF, 2'd0, 0,  0, 16'hFFFF, 16'd8);
        tbl[8]  = mk(0, 0, 0, 0, 16'h1234, 2'd3, 0,  0, 16'h0000, 16'd9);
        tbl[9]  = mk(0, 0, 1, 0, 16'h0000, 2'd3, 1,  0, 16'h0004, 16'd10);
        tbl[10] = mk(1, 1, 1, 0, 16'h0000, 2'd0, 1,  1, 16'h0005, 16'd11);
        tbl[11] = mk(1, 0, 0, 0, 16'h0000, 2'd0, 0, 14, 16'h0006, 16'd12);

        // Reset state
        repeat (3) @(negedge clk);
        check("reset stage", stage, 3'd0);
        check("reset pc", pc, 16'h0000);
        check("reset instr_count", instr_count, 16'd0);
        check("reset halted", halted, 1'b0);
        check("reset bus_err", bus_err, 1'b0);
        check("reset imem_req gated", imem_req, 1'b0);
        check("reset dmem_req", dmem_req, 1'b0);
        rst = 1'b1;
        #1;
        check("release imem_req", imem_req, 1'b1);

        // Instruction table
        for (int i = 0; i < 12; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

        // Stall in EXECUTE and WRITEBACK
        v = mk(0, 0, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0007, 16'd13);
        drive_instr(v);
        wait_stage("stall", 3'd2, 10);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall ex stage %0d", i), stage, 3'd2);
            check($sformatf("stall ex pc %0d", i), pc, 16'h0006);
        end
        stall = 1'b0;
        @(negedge clk);
        check("stall wb entered", stage, 3'd5);
        stall = 1'b1;
        #1;
        check("stall wb strobe low", rf_we_strobe, 1'b0);
        repeat (2) @(negedge clk);
        check("stall wb stage", stage, 3'd5);
        check("stall wb pc", pc, 16'h0006);
        check("stall wb count", instr_count, 16'd12);
        stall = 1'b0;
        #1;
        check("unstall wb strobe", rf_we_strobe, 1'b1);
        @(negedge clk);
        check("stall done stage", stage, 3'd0);
        check("stall done pc", pc, 16'h0007);
        check("stall done count", instr_count, 16'd13);

        // Halt and resume
        wb_en = 1'b0;
        halt_req = 1'b1;
        wait_stage("halt", 3'd6, 10);
        halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("halted %0d", i), halted, 1'b1);
            check($sformatf("halt imem_req %0d", i), imem_req, 1'b0);
            check($sformatf("halt pc %0d", i), pc, 16'h0007);
            @(negedge clk);
        end
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("resume stage", stage, 3'd0);
        check("resume halted", halted, 1'b0);
        check("resume pc", pc, 16'h0008);
        check("resume count", instr_count, 16'd14);

        // Data-bus timeout
        v = mk(1, 1, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0000, 16'd0);
        drive_instr(v);
        wait_stage("timeout", 3'd4, 10);
        begin
            int w;
            w = 0;
            while (stage == 3'd4 && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("timeout wait cycles", w, 15);
        end
        check("timeout stage", stage, 3'd7);
        check("timeout bus_err", bus_err, 1'b1);
        check("timeout dmem_req", dmem_req, 1'b0);
        check("timeout imem_req", imem_req, 1'b0);
        repeat (100) @(negedge clk);
        check("error persists", stage, 3'd7);
        check("error pc frozen", pc, 16'h0008);
        check("error bus_err sticky", bus_err, 1'b1);
        rst = 1'b0;
        #1;
        check("error reset stage", stage, 3'd0);
        check("error reset bus_err", bus_err, 1'b0);
        check("error reset pc", pc, 16'h0000);
        @(negedge clk);
        rst = 1'b1;

        // Retired-count saturation
        force dut.instr_count = 16'hFFFE;
        #1;
        release dut.instr_count;
        run_instr("sat0", mk(0, 0, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0001, 16'hFFFF));
        run_instr("sat1", mk(0, 0, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0002, 16'hFFFF));
        run_instr("sat2", mk(0, 0, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0003, 16'hFFFF));

        // Reset in the middle of a data transaction
        v = mk(1, 1, 0, 0, 16'h0000, 2'd0, 1, 0, 16'h0000, 16'd0);
        drive_instr(v);
        wait_stage("midreset", 3'd4, 10);
        repeat (2) @(negedge clk);
        check("midreset dmem_req before", dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        check("midreset dmem_req", dmem_req, 1'b0);
        check("midreset imem_req", imem_req, 1'b0);
        check("midreset pc", pc, 16'h0000);
        check("midreset stage", stage, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset release imem_req", imem_req, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
